// File: rtl/point_loader.sv
// point_loader: assembles M, x, y from a 64-bit word stream and reduces x, y mod q.
// It then presents the projective point (x, y, 1) and M to the core until the core accepts it.
module point_loader #(
    parameter logic [254:0] Q = {{250{1'b1}}, 5'b01101},
    parameter int N_WORDS = 12
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    input  logic [63:0]  i_in_data,
    output logic         o_in_ready,
    output logic         o_ld_valid,
    input  logic         i_ld_ready,
    output logic [255:0] o_ld_scalar,
    output logic [254:0] o_ld_xmp,
    output logic [254:0] o_ld_ymp,
    output logic [254:0] o_ld_zmp
);
    typedef enum logic [1:0] {RECV, RED_X, RED_Y, HOLD} state_t;
    state_t state, nxt;
    logic [3:0] cnt;
    logic [255:0] m, x, y, sel, s;
    logic [254:0] red;
    logic take, last;
    assign o_in_ready = state == RECV;
    assign o_ld_valid = state == HOLD;
    assign take = i_in_valid & o_in_ready;
    assign last = cnt == 4'(N_WORDS - 1);
    // One reducer is shared between x and y; 2^255 == 19 (mod q) folds the top bit in.
    assign sel = (state == RED_Y) ? y : x;
    assign s = {1'b0, sel[254:0]} + (sel[255] ? 256'd19 : 256'd0);
    assign red = (s >= {1'b0, Q}) ? 255'(s - {1'b0, Q}) : s[254:0];
    always_comb begin
        nxt = state;
        case (state)
            RECV:  nxt = (take && last) ? RED_X : RECV;
            RED_X: nxt = RED_Y;
            RED_Y: nxt = HOLD;
            HOLD:  nxt = i_ld_ready ? RECV : HOLD;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= RECV;
            cnt   <= '0;
            m     <= '0;
            x     <= '0;
            y     <= '0;
        end else begin
            state <= nxt;
            if (take) begin
                cnt <= last ? 4'd0 : cnt + 4'd1;
                case (cnt[3:2])
                    2'd0:    m[{~cnt[1:0], 6'd0} +: 64] <= i_in_data;
                    2'd1:    x[{~cnt[1:0], 6'd0} +: 64] <= i_in_data;
                    default: y[{~cnt[1:0], 6'd0} +: 64] <= i_in_data;
                endcase
            end
            if (state == RED_X) x <= {1'b0, red};
            if (state == RED_Y) y <= {1'b0, red};
        end
    end
    assign o_ld_scalar = m;
    assign o_ld_xmp = x[254:0];
    assign o_ld_ymp = y[254:0];
    assign o_ld_zmp = 255'd1;
endmodule

// File: tb/tb_point_loader.sv
// tb_point_loader: directed and randomized jobs checked against a mod-q reference model.
module tb_point_loader;
    localparam logic [255:0] QQ = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFED;
    logic         i_clk = 0, i_rst = 0, i_in_valid = 0, i_ld_ready = 0;
    logic [63:0]  i_in_data = '0;
    logic         o_in_ready, o_ld_valid;
    logic [255:0] o_ld_scalar;
    logic [254:0] o_ld_xmp, o_ld_ymp, o_ld_zmp;
    int vectors = 0, errs = 0, cyc = 0, valid_cyc = 0;

    point_loader dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_in_ready(o_in_ready), .o_ld_valid(o_ld_valid), .i_ld_ready(i_ld_ready),
        .o_ld_scalar(o_ld_scalar), .o_ld_xmp(o_ld_xmp), .o_ld_ymp(o_ld_ymp), .o_ld_zmp(o_ld_zmp)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drives one word, idling first for a random number of cycles (gap_pct = chance of idling).
    task automatic send_word(input logic [63:0] w, input int gap_pct);
        while ($urandom_range(99) < gap_pct) begin
            i_in_valid = 0;
            i_in_data = 64'(rnd256());
            @(negedge i_clk);
        end
        check("in_ready_recv", 256'(o_in_ready), 256'd1);
        i_in_valid = 1;
        i_in_data = w;
        @(negedge i_clk);
        i_in_valid = 0;
    endtask

    // Streams a job, waits for o_ld_valid and checks it against the modular reference.
    task automatic run_job(input logic [255:0] m, input logic [255:0] x, input logic [255:0] y, input int gap_pct);
        logic [767:0] cat;
        int n;
        cat = {m, x, y};
        for (int i = 0; i < 12; i++) send_word(cat[767 - 64*i -: 64], gap_pct);
        n = 0;
        while (!o_ld_valid && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        valid_cyc = cyc;
        check("latency", 256'(n), 256'd2);
        check("scalar", o_ld_scalar, m);
        check("xmp", 256'(o_ld_xmp), x % QQ);
        check("ymp", 256'(o_ld_ymp), y % QQ);
        check("zmp", 256'(o_ld_zmp), 256'd1);
        check("in_ready_hold", 256'(o_in_ready), 256'd0);
        if (i_ld_ready) begin
            @(negedge i_clk);
            check("valid_after_handoff", 256'(o_ld_valid), 256'd0);
            check("in_ready_after_handoff", 256'(o_in_ready), 256'd1);
        end
    endtask

    initial begin
        logic [255:0] bnd [5];
        logic [255:0] sm, sx, sy;
        int prev;
        bnd[0] = QQ;
        bnd[1] = QQ - 256'd1;
        bnd[2] = '1;
        bnd[3] = 256'd1 << 255;
        bnd[4] = (256'd1 << 255) + QQ;
        repeat (2) @(negedge i_clk);
        check("rst_in_ready", 256'(o_in_ready), 256'd1);
        check("rst_valid", 256'(o_ld_valid), 256'd0);
        check("rst_scalar", o_ld_scalar, 256'd0);
        check("rst_x", 256'(o_ld_xmp), 256'd0);
        check("rst_y", 256'(o_ld_ymp), 256'd0);
        check("rst_z", 256'(o_ld_zmp), 256'd1);
        i_rst = 1;
        // Basic job with the core always ready.
        i_ld_ready = 1;
        run_job(256'd1, 256'd9, 256'h20AE19A1B8A086B4E01EDD2C7748D14C923D4D7E6D7C61B229E9C5A27ECED3D9, 0);
        // Reduction boundaries on x, then on y.
        for (int i = 0; i < 5; i++) run_job(rnd256(), bnd[i], rnd256(), 0);
        for (int i = 0; i < 5; i++) run_job(rnd256(), rnd256(), bnd[i], 0);
        // Backpressure: hold for 20 cycles while offering words that must not be consumed.
        i_ld_ready = 0;
        run_job(rnd256(), rnd256(), rnd256(), 0);
        sm = o_ld_scalar;
        sx = 256'(o_ld_xmp);
        sy = 256'(o_ld_ymp);
        for (int i = 0; i < 20; i++) begin
            i_in_valid = 1;
            i_in_data = 64'(rnd256());
            @(negedge i_clk);
            check("bp_valid", 256'(o_ld_valid), 256'd1);
            check("bp_in_ready", 256'(o_in_ready), 256'd0);
            check("bp_scalar", o_ld_scalar, sm);
            check("bp_x", 256'(o_ld_xmp), sx);
            check("bp_y", 256'(o_ld_ymp), sy);
        end
        i_in_valid = 0;
        i_ld_ready = 1;
        @(negedge i_clk);
        check("bp_handoff", 256'(o_ld_valid), 256'd0);
        check("bp_in_ready_after", 256'(o_in_ready), 256'd1);
        @(negedge i_clk);
        check("bp_single_handoff", 256'(o_ld_valid), 256'd0);
        // Gapped input at about 30% valid duty.
        run_job(rnd256(), rnd256(), rnd256(), 70);
        run_job(rnd256(), rnd256(), rnd256(), 70);
        // Reset after word 6 discards the partial job.
        for (int i = 0; i < 7; i++) send_word(64'(rnd256()), 0);
        i_rst = 0;
        @(negedge i_clk);
        i_rst = 1;
        check("mid_rst_valid", 256'(o_ld_valid), 256'd0);
        check("mid_rst_in_ready", 256'(o_in_ready), 256'd1);
        check("mid_rst_scalar", o_ld_scalar, 256'd0);
        run_job(rnd256(), rnd256(), rnd256(), 0);
        // Reset while holding a job drops o_ld_valid.
        i_ld_ready = 0;
        run_job(rnd256(), rnd256(), rnd256(), 0);
        i_rst = 0;
        @(negedge i_clk);
        i_rst = 1;
        check("hold_rst_valid", 256'(o_ld_valid), 256'd0);
        check("hold_rst_in_ready", 256'(o_in_ready), 256'd1);
        // Three back-to-back jobs are 15 cycles apart.
        i_ld_ready = 1;
        run_job(rnd256(), rnd256(), rnd256(), 0);
        for (int j = 0; j < 2; j++) begin
            prev = valid_cyc;
            run_job(rnd256(), rnd256(), rnd256(), 0);
            check("b2b_spacing", 256'(valid_cyc - prev), 256'd15);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/point_loader.md
Name: point_loader

Overview:
- Input-side counterpart of the affine output serializer in the scalar-multiplication datapath.
- Accepts a 64-bit word stream over valid/ready and assembles a 256-bit scalar M plus affine coordinates x and y.
- Reduces x and y mod q = 2^255-19 and presents the projective point (x, y, Z=1) with M to the scalar/point-adder core over a valid/ready handshake.
- Holds the data until the core accepts it, then accepts the next job.

Parameters:
Q, 255'h7FFF...FFED, field modulus 2^255-19
N_WORDS, 12, input words per job (4 each for M, x, y)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous active-low (asserted when 0)
i_in_valid  in  1  input word valid
i_in_data  in  64  input word
o_in_ready  out  1  loader can accept a word
o_ld_valid  out  1  job data valid to core
i_ld_ready  in  1  core accepts job
o_ld_scalar  out  256  scalar M, unmodified
o_ld_xmp  out  255  x mod q
o_ld_ymp  out  255  y mod q
o_ld_zmp  out  255  constant 1

Behaviour:
- Reset (i_rst==0 at a clock edge):
  - state=RECV, word counter=0.
  - o_in_ready=1, o_ld_valid=0.
  - Scalar, x and y registers are all 0. o_ld_zmp is 1 at all times.
- Word order: MSB-first within each field, fields in the order M, x, y.
  - Words 0-3 fill M[255:192], M[191:128], M[127:64], M[63:0].
  - Words 4-7 fill x the same way; words 8-11 fill y the same way.
- State RECV:
  - o_in_ready=1.
  - Word transfer = i_in_valid & o_in_ready at a rising edge. Each transfer writes the addressed 64-bit slice and increments the counter.
  - No transfer: registers and counter hold.
  - Transfer at counter==11: counter wraps to 0, go to RED_X.
- State RED_X (1 cycle), o_in_ready=0:
  - Raw 256-bit x = h*2^255 + l, where h = bit 255 and l = bits 254:0.
  - Compute s = l + 19*h (256-bit).
  - If s >= Q, x' = s - Q; otherwise x' = s. Register x'[254:0].
  - One subtraction always suffices, since s <= 2^255+18 and s-Q <= 37.
- State RED_Y (1 cycle): same as RED_X, applied to y. Then go to HOLD.
  - A single shared reducer is used: a mux selects x or y.
- State HOLD:
  - o_ld_valid=1, o_in_ready=0.
  - Outputs are stable while o_ld_valid=1 and i_ld_ready=0.
  - Job handoff = o_ld_valid & i_ld_ready at an edge. On handoff go to RECV with o_ld_valid=0 the next cycle.
- Latency: 3 edges from the 12th word transfer to o_ld_valid=1 (RED_X, RED_Y, HOLD entry).
- Output stability outside HOLD:
  - o_ld_scalar, o_ld_xmp and o_ld_ymp keep the last job's values until overwritten.
  - Consumers must sample them only when o_ld_valid=1.
- Edge cases:
  - i_ld_ready high before HOLD: no effect.
  - i_in_valid high outside RECV: ignored, no word consumed because o_in_ready=0.
  - Reset mid-stream or in HOLD: the partial job is discarded, counter=0, o_ld_valid drops the next cycle.
  - A new job's first word may be accepted in the cycle after the handoff edge, so throughput is 12 words plus 3 cycles per job.
- Scalar: passed through at 256 bits with no reduction.
- Implementation: no combinational path from i_in_valid or i_ld_ready to any output; o_in_ready and o_ld_valid are decoded from the state register only.

Test Plan:
1. Reset, then stream M=1, x=9, y=0x20AE19A1B8A086B4E01EDD2C7748D14C923D4D7E6D7C61B229E9C5A27ECED3D9 with i_ld_ready=1. Expect o_ld_valid on the 3rd edge after word 11, o_ld_xmp=9, o_ld_ymp=y, o_ld_zmp=1, and o_in_ready=1 the cycle after handoff.
2. Reduction boundaries on x:
   - x=Q gives 0.
   - x=Q-1 gives Q-1.
   - x=2^256-1 gives 37.
   - x=2^255 gives 19.
   - x=2^255+Q gives 19.
   The same set is repeated on y.
3. Backpressure:
   - Hold i_ld_ready=0 for 20 cycles in HOLD: outputs stable, o_in_ready=0, and i_in_valid=1 words are not consumed.
   - Raise i_ld_ready: exactly one handoff occurs.
4. Gapped input: i_in_valid toggles randomly with a 30% duty cycle over 12 words. The assembled M, x, y are bit-exact to the reference model and the counter never advances on invalid cycles.
5. Drive i_rst=0 after word 6, then send a full new job. Only the new job's values appear, and no spurious o_ld_valid is raised.
6. Send 3 back-to-back jobs with i_ld_ready=1 constant. Expect 3 handoffs spaced 15 cycles apart, in order, with correct data.
